fan_drive_ctrl: RTL and testbench

Downstream stage of the room ventilation block. It consumes the 1-bit ventilation request and drives the fan motor with a soft-start/soft-stop PWM. It enforces minimum on and off times to protect the motor, and can optionally detect a stalled fan from its tachometer. Its outputs go straight to the fan driver pin and to the room status logic.

---
 rtl/smart_room_pkg.sv | 25 ++
 rtl/fan_pwm_gen.sv | 33 +++
 rtl/fan_drive_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_fan_drive_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/smart_room_pkg.sv
// Shared types and default constants for the room ventilation blocks.
package smart_room_pkg;

   typedef enum logic [2:0] {
      OFF       = 3'd0,
      RAMP_UP   = 3'd1,
      RUN       = 3'd2,
      RAMP_DOWN = 3'd3,
      COOLDOWN  = 3'd4,
      FAULT     = 3'd5
   } fan_state_t;

   localparam int FAN_PWM_BITS        = 8;
   localparam int FAN_RAMP_STEP       = 32;
   localparam int FAN_RAMP_PERIODS    = 1;
   localparam int FAN_MIN_ON_PERIODS  = 16;
   localparam int FAN_MIN_OFF_PERIODS = 8;
   localparam int FAN_STALL_PERIODS   = 4;

   // Width needed to hold 0..max_val, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Free-running PWM counter, period-boundary pulse and registered comparator.
// pb is high for the single cycle where the counter sits at its maximum.
module fan_pwm_gen
   import smart_room_pkg::*;
#(
   parameter int PWM_BITS = FAN_PWM_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PWM_BITS-1:0] duty,
   output logic                pb,
   output logic                fan_pwm
);

   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
   localparam logic [PWM_BITS-1:0] CNT_ONE  = 1;

   logic [PWM_BITS-1:0] pwm_cnt;

   assign pb = (pwm_cnt == DUTY_MAX);

   // Counter wraps naturally; output is the registered compare so the pin is glitch-free.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_cnt <= '0;
         fan_pwm <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + CNT_ONE;
         fan_pwm <= (pwm_cnt < duty);
      end
   end

endmodule

// File: rtl/fan_drive_ctrl.sv
// Fan motor drive: soft-start/soft-stop PWM with minimum on/off times.
// Optional stall detection from the tachometer is built when the macro
// FAN_STALL_DETECT_EN is defined; otherwise tach_pulse is ignored and stall is 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OFF       | motor idle, duty 0, waiting for vent_req
// RAMP_UP   | duty rises by RAMP_STEP every RAMP_PERIODS periods
// RUN       | full duty, waiting for a stop request
// RAMP_DOWN | duty falls by RAMP_STEP every RAMP_PERIODS periods
// COOLDOWN  | duty 0, requests ignored for MIN_OFF_PERIODS periods
// FAULT     | stalled motor, duty 0, stall flag high until request drops
module fan_drive_ctrl
   import smart_room_pkg::*;
#(
   parameter int PWM_BITS        = FAN_PWM_BITS,
   parameter int RAMP_STEP       = FAN_RAMP_STEP,
   parameter int RAMP_PERIODS    = FAN_RAMP_PERIODS,
   parameter int MIN_ON_PERIODS  = FAN_MIN_ON_PERIODS,
   parameter int MIN_OFF_PERIODS = FAN_MIN_OFF_PERIODS,
   parameter int STALL_PERIODS   = FAN_STALL_PERIODS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                vent_req,
   input  logic                tach_pulse,
   output logic                fan_pwm,
   output logic [PWM_BITS-1:0] duty,
   output logic                fan_on,
   output logic                stall
);

   localparam int ON_W    = cnt_width(MIN_ON_PERIODS);
   localparam int OFF_W   = cnt_width(MIN_OFF_PERIODS);
   localparam int RAMP_W  = cnt_width(RAMP_PERIODS);

   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
   localparam logic [PWM_BITS:0]   STEP_W    = RAMP_STEP[PWM_BITS:0];
   localparam logic [ON_W-1:0]     ON_MIN    = ON_W'(MIN_ON_PERIODS);
   localparam logic [ON_W-1:0]     ON_ONE    = 1;
   localparam logic [OFF_W-1:0]    OFF_LOAD  = OFF_W'(MIN_OFF_PERIODS);
   localparam logic [OFF_W-1:0]    OFF_ONE   = 1;
   localparam logic [RAMP_W-1:0]   RAMP_LOAD = RAMP_W'(RAMP_PERIODS - 1);
   localparam logic [RAMP_W-1:0]   RAMP_ONE  = 1;

   fan_state_t          state;
   fan_state_t          state_nxt;
   logic [PWM_BITS-1:0] duty_nxt;
   logic [PWM_BITS:0]   duty_sum;
   logic [PWM_BITS-1:0] duty_up;
   logic [PWM_BITS-1:0] duty_dn;
   logic [ON_W-1:0]     on_cnt;
   logic [OFF_W-1:0]    off_cnt;
   logic [RAMP_W-1:0]   ramp_cnt;
   logic                pb;
   logic                step_due;
   logic                stop_ok;
   logic                stall_hit;

   fan_pwm_gen #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clk     (clk),
      .rst     (rst),
      .duty    (duty),
      .pb      (pb),
      .fan_pwm (fan_pwm)
   );

`ifdef FAN_STALL_DETECT_EN
   localparam int STALL_W = cnt_width(STALL_PERIODS);
   localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_PERIODS);
   localparam logic [STALL_W-1:0] STALL_ONE  = 1;

   logic               tach_meta;
   logic               tach_sync;
   logic               tach_prev;
   logic               tach_edge;
   logic [STALL_W-1:0] stall_cnt;

   assign tach_edge = tach_sync & ~tach_prev;
   assign stall_hit = pb && !tach_edge && (stall_cnt <= STALL_ONE);
   assign stall     = (state == FAULT);

   // Two-flop synchronizer for the asynchronous tach, plus one flop for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tach_meta <= 1'b0;
         tach_sync <= 1'b0;
         tach_prev <= 1'b0;
      end else begin
         tach_meta <= tach_pulse;
         tach_sync <= tach_meta;
         tach_prev <= tach_sync;
      end
   end

   // Periods left in RUN before a missing tach counts as a stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if ((state_nxt == RUN && state != RUN) || tach_edge) begin
         stall_cnt <= STALL_LOAD;
      end else if (pb && state == RUN && stall_cnt != '0) begin
         stall_cnt <= stall_cnt - STALL_ONE;
      end
   end
`else
   logic unused_tach;

   assign unused_tach = tach_pulse ^ (STALL_PERIODS > 0);
   assign stall_hit   = 1'b0;
   assign stall       = 1'b0;
`endif

   // Saturating arithmetic at one extra bit so an overshoot clamps to full duty.
   assign duty_sum = {1'b0, duty} + STEP_W;
   assign duty_up  = (duty_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : duty_sum[PWM_BITS-1:0];
   assign duty_dn  = ({1'b0, duty} <= STEP_W) ? '0 : (duty - STEP_W[PWM_BITS-1:0]);

   assign step_due = pb && (ramp_cnt == '0);
   assign stop_ok  = !vent_req && (on_cnt >= ON_MIN);
   assign fan_on   = (state == RAMP_UP) || (state == RUN) || (state == RAMP_DOWN);

   // Next state and next duty; a state change always wins over a duty step in the same cycle.
   always_comb begin
      state_nxt = state;
      duty_nxt  = duty;
      case (state)
         OFF: begin
            duty_nxt = '0;
            if (vent_req) state_nxt = RAMP_UP;
         end
         RAMP_UP: begin
            if (stop_ok) begin
               state_nxt = RAMP_DOWN;
            end else if (step_due) begin
               duty_nxt = duty_up;
               if (duty_up == DUTY_MAX) state_nxt = RUN;
            end
         end
         RUN: begin
            duty_nxt = DUTY_MAX;
            if (stop_ok) begin
               state_nxt = RAMP_DOWN;
            end else if (stall_hit) begin
               state_nxt = FAULT;
               duty_nxt  = '0;
            end
         end
         RAMP_DOWN: begin
            if (vent_req) begin
               state_nxt = RAMP_UP;
            end else if (step_due) begin
               duty_nxt = duty_dn;
               if (duty_dn == '0) state_nxt = COOLDOWN;
            end
         end
         COOLDOWN: begin
            duty_nxt = '0;
            if (pb && off_cnt <= OFF_ONE) state_nxt = OFF;
         end
         FAULT: begin
            duty_nxt = '0;
            if (pb && !vent_req) state_nxt = COOLDOWN;
         end
         default: begin
            state_nxt = OFF;
            duty_nxt  = '0;
         end
      endcase
   end

   // State and applied duty registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= OFF;
         duty  <= '0;
      end else begin
         state <= state_nxt;
         duty  <= duty_nxt;
      end
   end

   // Periods since leaving OFF; only needs to reach MIN_ON_PERIODS, so it stops there.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         on_cnt <= '0;
      end else if (state == OFF) begin
         on_cnt <= '0;
      end else if (pb && state != COOLDOWN && on_cnt < ON_MIN) begin
         on_cnt <= on_cnt + ON_ONE;
      end
   end

   // Periods remaining until the next ramp step; restarts on any state change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ramp_cnt <= '0;
      end else if (state_nxt != state || step_due) begin
         ramp_cnt <= RAMP_LOAD;
      end else if (pb && ramp_cnt != '0) begin
         ramp_cnt <= ramp_cnt - RAMP_ONE;
      end
   end

   // Periods remaining in COOLDOWN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         off_cnt <= '0;
      end else if (state_nxt == COOLDOWN && state != COOLDOWN) begin
         off_cnt <= OFF_LOAD;
      end else if (pb && state == COOLDOWN && off_cnt != '0) begin
         off_cnt <= off_cnt - OFF_ONE;
      end
   end

endmodule

// File: tb/tb_fan_drive_ctrl.sv
// Bench for fan_drive_ctrl: a period-level behavioural model compared every
// cycle, plus hand-computed literal expectations at key cycles.
module tb_fan_drive_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       vent_req = 1'b0;
   logic       tach_pulse = 1'b0;
   logic       fan_pwm;
   logic [7:0] duty;
   logic       fan_on;
   logic       stall;

   int checks = 0;
   int errors = 0;
   int cyc;
   bit chk_en = 1'b0;
   bit tach_en = 1'b1;

   fan_drive_ctrl #(
      .PWM_BITS        (8),
      .RAMP_STEP       (32),
      .RAMP_PERIODS    (1),
      .MIN_ON_PERIODS  (16),
      .MIN_OFF_PERIODS (8),
      .STALL_PERIODS   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .vent_req   (vent_req),
      .tach_pulse (tach_pulse),
      .fan_pwm    (fan_pwm),
      .duty       (duty),
      .fan_on     (fan_on),
      .stall      (stall)
   );

   always #5 clk = ~clk;

   // clock edges since reset release
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // tach toggles slowly so a healthy fan never looks stalled
   initial forever begin
      repeat (50) @(negedge clk);
      if (tach_en) tach_pulse = ~tach_pulse;
   end

   // ---------------- behavioural model ----------------
   localparam int M_OFF = 0, M_UP = 1, M_RUN = 2, M_DN = 3, M_COOL = 4, M_FAULT = 5;
   int m_state, m_duty, m_pos, m_on, m_cool_pb, m_stall_pb, m_nst;
   bit m_pwm, m_pb, m_stop, m_edge, s0, s1, s2;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_state = M_OFF; m_duty = 0; m_pos = 0; m_on = 0;
         m_cool_pb = 0; m_stall_pb = 0; m_pwm = 0; s0 = 0; s1 = 0; s2 = 0;
      end else begin
         m_pb   = (m_pos == 255);
         m_edge = s1 && !s2;
         s2 = s1; s1 = s0; s0 = tach_pulse;
         m_pwm  = (m_pos < m_duty);
         m_stop = !vent_req && (m_on >= 16);
         m_nst  = m_state;
         case (m_state)
            M_OFF:  if (vent_req) m_nst = M_UP;
            M_UP: begin
               if (m_stop) m_nst = M_DN;
               else if (m_pb) begin
                  m_duty = (m_duty + 32 > 255) ? 255 : m_duty + 32;
                  if (m_duty == 255) m_nst = M_RUN;
               end
            end
            M_RUN: begin
               if (m_stop) m_nst = M_DN;
`ifdef FAN_STALL_DETECT_EN
               else if (m_edge) m_stall_pb = 0;
               else if (m_pb) begin
                  m_stall_pb = m_stall_pb + 1;
                  if (m_stall_pb == 4) begin
                     m_nst = M_FAULT;
                     m_duty = 0;
                  end
               end
`endif
            end
            M_DN: begin
               if (vent_req) m_nst = M_UP;
               else if (m_pb) begin
                  m_duty = (m_duty < 32) ? 0 : m_duty - 32;
                  if (m_duty == 0) m_nst = M_COOL;
               end
            end
            M_COOL: begin
               if (m_pb) begin
                  m_cool_pb = m_cool_pb + 1;
                  if (m_cool_pb == 8) m_nst = M_OFF;
               end
            end
            M_FAULT: if (m_pb && !vent_req) m_nst = M_COOL;
            default: m_nst = M_OFF;
         endcase
         if (m_state == M_OFF) m_on = 0;
         else if (m_pb && m_state != M_COOL && m_on < 16) m_on = m_on + 1;
         if (m_nst == M_RUN && m_state != M_RUN) m_stall_pb = 0;
         if (m_nst == M_COOL && m_state != M_COOL) m_cool_pb = 0;
         m_state = m_nst;
         m_pos = (m_pos + 1) % 256;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (rst && chk_en) begin
         check("duty", int'(duty), m_duty);
         check("fan_pwm", int'(fan_pwm), int'(m_pwm));
         check("fan_on", int'(fan_on), int'(m_state == M_UP || m_state == M_RUN || m_state == M_DN));
         check("stall", int'(stall), int'(m_state == M_FAULT));
      end
   end

   task automatic tick_to(input int n);
      int guard = 0;
      while (cyc != n && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != n) begin
         checks++;
         errors++;
         $display("FAIL wait_cyc: got %0d expected %0d", cyc, n);
      end
   endtask

   task automatic do_reset(input bit vr);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vent_req = vr;
      rst = 1'b1;
      chk_en = 1'b1;
   endtask

   int hi;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // idle
      do_reset(1'b0);
      check("rst_duty", int'(duty), 0);
      check("rst_fan_on", int'(fan_on), 0);
      tick_to(1000);
      check("idle_duty", int'(duty), 0);
      check("idle_pwm", int'(fan_pwm), 0);
      check("idle_fan_on", int'(fan_on), 0);

      // start and ramp to full
      vent_req = 1'b1;
      tick_to(1024);
      check("first_step", int'(duty), 32);
      check("up_fan_on", int'(fan_on), 1);
      tick_to(2816);
      check("full_duty", int'(duty), 255);
      hi = 0;
      repeat (256) begin
         @(negedge clk);
         hi += int'(fan_pwm);
      end
      check("full_high_cnt", hi, 255);

      // short request: min on time holds it, then full ramp down and cooldown
      do_reset(1'b1);
      tick_to(768);
      vent_req = 1'b0;
      tick_to(2048);
      check("ramp_continues", int'(duty), 255);
      tick_to(4352);
      check("down_first", int'(duty), 223);
      tick_to(6144);
      check("down_zero", int'(duty), 0);
      check("cool_fan_on", int'(fan_on), 0);
      tick_to(7000);
      vent_req = 1'b1;
      tick_to(8192);
      check("cool_ignores_req", int'(fan_on), 0);
      tick_to(8193);
      check("restart_after_cool", int'(fan_on), 1);
      tick_to(8448);
      check("restart_step", int'(duty), 32);

      // re-request during ramp down
      do_reset(1'b1);
      tick_to(300);
      vent_req = 1'b0;
      tick_to(5376);
      check("down_95", int'(duty), 95);
      tick_to(5400);
      vent_req = 1'b1;
      tick_to(5401);
      check("resume_fan_on", int'(fan_on), 1);
      tick_to(5632);
      check("resume_127", int'(duty), 127);
      tick_to(5888);
      check("resume_159", int'(duty), 159);

`ifdef FAN_STALL_DETECT_EN
      // stall: no tach edges while running
      tach_en = 1'b0;
      tach_pulse = 1'b0;
      do_reset(1'b1);
      tick_to(3071);
      check("pre_stall", int'(stall), 0);
      check("pre_stall_duty", int'(duty), 255);
      tick_to(3072);
      check("stall_set", int'(stall), 1);
      check("stall_duty", int'(duty), 0);
      tick_to(3100);
      vent_req = 1'b0;
      tick_to(3327);
      check("stall_held", int'(stall), 1);
      tick_to(3328);
      check("stall_clear", int'(stall), 0);
      check("stall_fan_on", int'(fan_on), 0);
      tach_en = 1'b1;
`endif

      // asynchronous reset mid-ramp
      do_reset(1'b1);
      tick_to(1100);
      check("mid_duty", int'(duty), 128);
      check("mid_pwm", int'(fan_pwm), 1);
      #2;
      rst = 1'b0;
      vent_req = 1'b0;
      #1;
      check("async_pwm", int'(fan_pwm), 0);
      check("async_duty", int'(duty), 0);
      check("async_fan_on", int'(fan_on), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      tick_to(600);
      check("post_rst_fan_on", int'(fan_on), 0);
      check("post_rst_duty", int'(duty), 0);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
